mx_block_sequencer: RTL and testbench
=====================================

// Module: mx_block_sequencer
//
// PURPOSE
//   Streams bf16 elements in, LANES per beat, and groups them into blocks of K.
//   Each completed block is presented to the combinational bf16->MXINT converter.
//   The converter result (K elements plus a shared exponent) is captured in an output
//   register and delivered downstream over a valid/ready handshake.
//   Sits between the bf16 producer (activation/weight stream) and MX block storage.
//
// PARAMETERS
//   K          32  elements per MX block; K % LANES == 0
//   LANES      4   bf16 elements accepted per input beat; power of 2
//   BIT_WIDTH  8   MXINT element width
//
// PORTS
//   i_clk       in   1             clock; all logic on rising edge
//   i_rst       in   1             synchronous, active-high reset
//   i_valid     in   1             input beat valid
//   o_ready     out  1             input beat ready
//   i_data      in   [LANES][16]   bf16 elements; lane j -> slot beat*LANES+j
//   i_last      in   1             beat is final of a (possibly short) block
//   o_valid     out  1             output block valid
//   i_ready     in   1             downstream ready
//   o_mx_vec    out  [K][BIT_WIDTH] MXINT elements
//   o_mx_exp    out  8             shared exponent
//   o_mx_count  out  $clog2(K+1)   real (non-pad) elements in block, 1..K
//
// BEHAVIOUR
// - Beat transfers when i_valid && o_ready. Block transfers when o_valid && i_ready.
// - Reset (i_rst=1 at an edge):
//   - state=FILL, beat_cnt=0, out_valid=0.
//   - o_valid=0 and o_mx_vec/o_mx_exp/o_mx_count=0.
//   - o_ready is forced 0 while i_rst is high.
//   - Reset mid-fill or mid-hold discards all partial and held data.
// - State FILL:
//   - o_ready = 1.
//   - On an accepted beat, write the lanes to buf[beat_cnt*LANES +: LANES] and increment beat_cnt.
//   - If the beat is the (K/LANES)th or carries i_last, latch fill_cnt = (beat_cnt+1)*LANES and go to FULL.
//   - i_last on the natural final beat is identical to a full block.
//   - Gaps in i_valid are allowed; they cause no state change.
// - State FULL:
//   - o_ready = 0.
//   - Converter input slot i = (i < fill_cnt) ? buf[i] : 16'h0000. Padding is +0, so it never affects the exponent max.
//   - Capture when out_valid==0 || i_ready (the output is free this cycle):
//     - o_mx_vec <= converter elements, o_mx_exp <= converter exponent, o_mx_count <= fill_cnt.
//     - out_valid <= 1, beat_cnt <= 0, next state FILL.
//   - Otherwise hold in FULL (stall).
// - Output register:
//   - o_valid = out_valid.
//   - Data is stable while o_valid && !i_ready.
//   - A handshake with no capture in the same cycle clears out_valid.
//   - A handshake and a capture in the same cycle load the new block with o_valid staying 1 (no bubble).
// - Latency: accepted final beat at cycle t -> o_valid at t+2 when the output is free.
// - Throughput: one block per K/LANES+1 cycles; the FULL cycle is a mandatory input bubble.
// - Ordering: blocks leave in arrival order. A block filling while the previous one is held is allowed (one block of overlap).
// - Width rules:
//   - beat_cnt is $clog2(K/LANES) bits wide and never wraps; it is cleared on the FULL->FILL transition.
//   - fill_cnt is always a multiple of LANES.
//   - The converter is purely combinational, so no internal X may reach the output registers.
//
// STRUCTURE
// - Shared package mx_pkg holds:
//   - typedef logic [15:0] bf16_t;
//   - localparam bf16_t BF16_POS_ZERO = 16'h0000;
//   - typedef enum logic {FILL, FULL} mx_seq_state_t;
// - One sub-module: the existing combinational converter convbf16tomxi8, instantiated as u_conv with k=K, bit_width=BIT_WIDTH.
// - The FSM, beat counter, input buffer and output register are local to this module.
//
// TESTING  (K=32, LANES=4, BIT_WIDTH=8; scoreboard = golden bf16->MX model)
// 1. 8 beats of 0x3F80 (1.0), i_ready=1 -> one block; o_mx_exp=0x7F, count=32, elems match model; o_valid 2 cycles after beat 8.
// 2. 3 beats of 0x4000 (2.0), i_last on beat 3 -> count=12, exp=0x80, slots 12..31 equal model(+0)=0x00.
// 3. i_ready=0 for 20 cycles after block A; stream block B -> B fills, FSM holds FULL with o_ready=0.
//    On the first i_ready: A out, B captured the same cycle, then B out; no loss, order A,B.
// 4. Continuous input and i_ready=1, 4 blocks -> o_ready low exactly 1 cycle per block; 36 cycles for 32 beats.
// 5. i_rst for 1 cycle after 5 beats -> no o_valid; the next 8 beats form a block starting at slot 0 with count=32.
// 6. Random i_valid/i_ready gaps, random i_last, 200 blocks -> all blocks match model; data stable while stalled.

Source files
------------

// File: rtl/mx_pkg.sv
// Shared bf16/MX types and helpers for the MX block sequencer and its converter.
// Purely declarative: no logic, no latency, no flow control.
package mx_pkg;

  typedef logic [15:0] bf16_t;

  localparam bf16_t BF16_POS_ZERO = 16'h0000;

  typedef enum logic {FILL, FULL} mx_seq_state_t;

  function automatic logic [7:0] bf16_exp(input bf16_t x);
    return x[14:7];
  endfunction

  function automatic logic [6:0] bf16_man(input bf16_t x);
    return x[6:0];
  endfunction

endpackage

// File: rtl/mx_block_sequencer_if.sv
// Beat-in / block-out bundle of the MX block sequencer; master drives beats and ready,
// slave (the sequencer) drives input ready and the registered output block.
interface mx_block_sequencer_if
  import mx_pkg::*;
#(
  parameter int K         = 32,
  parameter int LANES     = 4,
  parameter int BIT_WIDTH = 8
);
  localparam int CNT_W = $clog2(K + 1);

  logic                        i_valid;
  logic                        o_ready;
  bf16_t [LANES-1:0]           i_data;
  logic                        i_last;
  logic                        o_valid;
  logic                        i_ready;
  logic [K-1:0][BIT_WIDTH-1:0] o_mx_vec;
  logic [7:0]                  o_mx_exp;
  logic [CNT_W-1:0]            o_mx_count;

  modport master (
    output i_valid, i_data, i_last, i_ready,
    input  o_ready, o_valid, o_mx_vec, o_mx_exp, o_mx_count
  );

  modport slave (
    input  i_valid, i_data, i_last, i_ready,
    output o_ready, o_valid, o_mx_vec, o_mx_exp, o_mx_count
  );

endinterface

// File: rtl/convbf16tomxi8.sv
// Combinational bf16 -> MXINT block converter: shared exponent is the largest biased exponent,
// each element is its signed mantissa aligned to it (truncated); zero/subnormal inputs flush to 0.
module convbf16tomxi8
  import mx_pkg::*;
#(
  parameter int k         = 32,
  parameter int bit_width = 8
) (
  input  bf16_t [k-1:0]                in_vec,
  output logic  [k-1:0][bit_width-1:0] out_vec,
  output logic  [7:0]                  out_exp
);
  // keep the top bit_width-1 bits of the 8-bit significand (hidden one included)
  localparam int PRE_SHIFT = 9 - bit_width;

  logic [7:0] max_exp;
  logic [7:0] e;
  logic [7:0] mag;
  logic [7:0] sval;

  always_comb begin
    max_exp = '0;
    e       = '0;
    mag     = '0;
    sval    = '0;
    out_vec = '0;
    for (int i = 0; i < k; i++) begin
      if (bf16_exp(in_vec[i]) > max_exp) max_exp = bf16_exp(in_vec[i]);
    end
    for (int i = 0; i < k; i++) begin
      e    = bf16_exp(in_vec[i]);
      mag  = {1'b1, bf16_man(in_vec[i])} >> PRE_SHIFT;
      mag  = mag >> (max_exp - e);
      if (e == 8'd0) mag = 8'd0;
      sval = in_vec[i][15] ? (8'd0 - mag) : mag;
      out_vec[i] = sval[bit_width-1:0];
    end
    out_exp = max_exp;
  end

endmodule

// File: rtl/mx_block_sequencer.sv
// Packs LANES bf16 per beat into K-element blocks and emits converted MX blocks; final beat -> o_valid 2 cycles later.
// o_ready drops for the one FULL cycle per block, longer while the output register is held by downstream.
module mx_block_sequencer
  import mx_pkg::*;
#(
  parameter int K         = 32,
  parameter int LANES     = 4,
  parameter int BIT_WIDTH = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  mx_block_sequencer_if.slave bus
);
  localparam int BEATS = K / LANES;
  localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W = $clog2(K + 1);

  mx_seq_state_t               state;
  logic [BC_W-1:0]             beat_cnt;
  logic [CNT_W-1:0]            fill_cnt;
  bf16_t [K-1:0]               blk_buf;
  logic                        out_valid;
  logic [K-1:0][BIT_WIDTH-1:0] mx_vec_q;
  logic [7:0]                  mx_exp_q;
  logic [CNT_W-1:0]            mx_count_q;

  bf16_t [K-1:0]               conv_in;
  logic [K-1:0][BIT_WIDTH-1:0] conv_vec;
  logic [7:0]                  conv_exp;

  logic beat_fire;
  logic final_beat;
  logic capture;

  assign bus.o_ready = (state == FILL) && !i_rst;
  assign beat_fire   = bus.i_valid && bus.o_ready;
  assign final_beat  = bus.i_last || (beat_cnt == BC_W'(BEATS - 1));
  assign capture     = (state == FULL) && (!out_valid || bus.i_ready);

  assign bus.o_valid    = out_valid;
  assign bus.o_mx_vec   = mx_vec_q;
  assign bus.o_mx_exp   = mx_exp_q;
  assign bus.o_mx_count = mx_count_q;

  // Slots past fill_cnt are stale from earlier blocks; +0 keeps them out of the exponent max.
  always_comb begin
    conv_in = '0;
    for (int i = 0; i < K; i++) begin
      conv_in[i] = (CNT_W'(i) < fill_cnt) ? blk_buf[i] : BF16_POS_ZERO;
    end
  end

  convbf16tomxi8 #(
    .k         (K),
    .bit_width (BIT_WIDTH)
  ) u_conv (
    .in_vec  (conv_in),
    .out_vec (conv_vec),
    .out_exp (conv_exp)
  );

  always_ff @(posedge i_clk) begin
    if (beat_fire) blk_buf[beat_cnt*LANES +: LANES] <= bus.i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= FILL;
      beat_cnt   <= '0;
      fill_cnt   <= '0;
      out_valid  <= 1'b0;
      mx_vec_q   <= '0;
      mx_exp_q   <= '0;
      mx_count_q <= '0;
    end else begin
      if (out_valid && bus.i_ready) out_valid <= 1'b0;
      case (state)
        FILL: begin
          if (beat_fire) begin
            if (final_beat) begin
              fill_cnt <= CNT_W'((int'(beat_cnt) + 1) * LANES);
              state    <= FULL;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        FULL: begin
          // a handshake in this same cycle frees the register, so the new block follows with no bubble
          if (capture) begin
            mx_vec_q   <= conv_vec;
            mx_exp_q   <= conv_exp;
            mx_count_q <= fill_cnt;
            out_valid  <= 1'b1;
            beat_cnt   <= '0;
            state      <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_mx_block_sequencer.sv
// Bench for mx_block_sequencer: per-scenario tasks against a real-arithmetic bf16->MX reference model.
module tb_mx_block_sequencer;
  import mx_pkg::*;

  localparam int K     = 32;
  localparam int LANES = 4;
  localparam int BW    = 8;
  localparam int BEATS = K / LANES;

  typedef struct packed {
    logic [K-1:0][BW-1:0] vec;
    logic [7:0]           ex;
    logic [5:0]           cnt;
  } blk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mx_block_sequencer_if #(.K(K), .LANES(LANES), .BIT_WIDTH(BW)) bus ();

  mx_block_sequencer #(.K(K), .LANES(LANES), .BIT_WIDTH(BW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   stab_viol = 0;
  int   rdy_low = 0;
  int   fire_cyc = 0;
  int   timeouts = 0;
  bit   last_in_fire = 1'b0;
  bit   held_vld = 1'b0;
  blk_t held;
  logic [15:0] part_q[$];
  blk_t exp_q[$];
  blk_t obs_q[$];
  int   obs_cyc[$];

  // value = (1 + m/128) * 2^(e-127); element = trunc(value / 2^(shared-127-6)) as signed int
  function automatic blk_t mx_model(input logic [15:0] q[$]);
    blk_t r;
    int emax, e, mag;
    real v, scale;
    logic [15:0] x;
    r    = '0;
    emax = 0;
    foreach (q[i]) if (int'(q[i][14:7]) > emax) emax = int'(q[i][14:7]);
    scale = 2.0 ** real'(emax - 133);
    for (int i = 0; i < K; i++) begin
      x = (i < q.size()) ? q[i] : 16'h0000;
      e = int'(x[14:7]);
      if (e == 0) mag = 0;
      else begin
        v   = (1.0 + real'(x[6:0]) / 128.0) * (2.0 ** real'(e - 127));
        mag = int'($floor(v / scale));
      end
      r.vec[i] = x[15] ? 8'(-mag) : 8'(mag);
    end
    r.ex  = 8'(emax);
    r.cnt = 6'(q.size());
    return r;
  endfunction

  function automatic logic [15:0] rand_bf16();
    logic [15:0] x;
    x[15]   = 1'($urandom_range(0, 1));
    x[6:0]  = 7'($urandom_range(0, 127));
    x[14:7] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(120, 134));
    return x;
  endfunction

  function automatic logic [LANES-1:0][15:0] rand_beat();
    logic [LANES-1:0][15:0] d;
    for (int j = 0; j < LANES; j++) d[j] = rand_bf16();
    return d;
  endfunction

  function automatic blk_t cur_out();
    return {bus.o_mx_vec, bus.o_mx_exp, bus.o_mx_count};
  endfunction

  // one clock: observe handshakes before the edge, update the reference, then advance
  task automatic tick();
    bit in_fire, out_fire;
    #2;
    in_fire  = bus.i_valid && bus.o_ready;
    out_fire = bus.o_valid && bus.i_ready;
    if (rst) begin
      part_q.delete();
      exp_q.delete();
      held_vld = 1'b0;
    end else begin
      if (held_vld && (!bus.o_valid || cur_out() !== held)) stab_viol++;
      held_vld = bus.o_valid && !bus.i_ready;
      held     = cur_out();
      if (!bus.o_ready) rdy_low++;
      if (out_fire) begin
        obs_q.push_back(cur_out());
        obs_cyc.push_back(cyc);
      end
      if (in_fire) begin
        for (int j = 0; j < LANES; j++) part_q.push_back(bus.i_data[j]);
        fire_cyc = cyc;
        if (bus.i_last || part_q.size() == K) begin
          exp_q.push_back(mx_model(part_q));
          part_q.delete();
        end
      end
    end
    last_in_fire = in_fire && !rst;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_beat(input logic [LANES-1:0][15:0] d, input bit last);
    int n = 0;
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    bus.i_last  = last;
    do begin
      tick();
      n++;
    end while (!last_in_fire && n < 100);
    if (!last_in_fire) timeouts++;
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < budget) begin
      tick();
      n++;
    end
    if (obs_q.size() < exp_q.size()) timeouts++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    bus.i_data  = '0;
    bus.i_ready = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_o_valid: got %b want 0", bus.o_valid); end
    n_cmp++; if (bus.o_ready !== 1'b0) begin n_err++; $display("FAIL reset_o_ready: got %b want 0", bus.o_ready); end
    n_cmp++; if (bus.o_mx_vec !== '0) begin n_err++; $display("FAIL reset_vec: got %h want 0", bus.o_mx_vec); end
    n_cmp++; if (bus.o_mx_exp !== 8'h00) begin n_err++; $display("FAIL reset_exp: got %h want 00", bus.o_mx_exp); end
    n_cmp++; if (bus.o_mx_count !== 6'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.o_mx_count); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.o_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_o_ready: got %b want 1", bus.o_ready); end
  endtask

  task automatic test_full_block();
    blk_t o, x;
    int t0 = timeouts;
    logic [LANES-1:0][15:0] d;
    for (int j = 0; j < LANES; j++) d[j] = 16'h3F80;
    bus.i_ready = 1'b1;
    for (int b = 0; b < BEATS; b++) send_beat(d, 1'b0);
    drain(20);
    n_cmp++; if (timeouts != t0) begin n_err++; $display("FAIL full_timeout: got %0d timeouts want 0", timeouts - t0); end
    n_cmp++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      n_err++; $display("FAIL full_nblocks: got %0d want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      x = exp_q.pop_front();
      n_cmp++; if (o.ex !== 8'h7F) begin n_err++; $display("FAIL full_exp: got %h want 7f", o.ex); end
      n_cmp++; if (o.cnt !== 6'd32) begin n_err++; $display("FAIL full_count: got %0d want 32", o.cnt); end
      n_cmp++; if (o !== x) begin n_err++; $display("FAIL full_block: got %h want %h", o, x); end
      n_cmp++; if (obs_cyc[0] !== fire_cyc + 2) begin n_err++; $display("FAIL full_latency: got %0d want %0d", obs_cyc[0] - fire_cyc, 2); end
    end
    obs_cyc.delete();
  endtask

  task automatic test_short_block();
    blk_t o, x;
    int t0 = timeouts;
    logic [LANES-1:0][15:0] d;
    for (int j = 0; j < LANES; j++) d[j] = 16'h4000;
    bus.i_ready = 1'b1;
    for (int b = 0; b < 3; b++) send_beat(d, b == 2);
    drain(20);
    n_cmp++;
    if (obs_q.size() != 1 || exp_q.size() != 1 || timeouts != t0) begin
      n_err++; $display("FAIL short_nblocks: got %0d want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      x = exp_q.pop_front();
      n_cmp++; if (o.cnt !== 6'd12) begin n_err++; $display("FAIL short_count: got %0d want 12", o.cnt); end
      n_cmp++; if (o.ex !== 8'h80) begin n_err++; $display("FAIL short_exp: got %h want 80", o.ex); end
      n_cmp++; if (o.vec[K-1:12] !== '0) begin n_err++; $display("FAIL short_pad: got %h want 0", o.vec[K-1:12]); end
      n_cmp++; if (o !== x) begin n_err++; $display("FAIL short_block: got %h want %h", o, x); end
    end
    obs_cyc.delete();
  endtask

  task automatic test_backpressure();
    blk_t o, x;
    int t0 = timeouts;
    int a_cyc;
    bus.i_ready = 1'b0;
    for (int b = 0; b < BEATS; b++) send_beat(rand_beat(), 1'b0);
    a_cyc = fire_cyc;
    for (int b = 0; b < 5; b++) send_beat(rand_beat(), b == 4);
    while (cyc < a_cyc + 20) tick();
    n_cmp++; if (bus.o_ready !== 1'b0) begin n_err++; $display("FAIL bp_o_ready: got %b want 0", bus.o_ready); end
    n_cmp++; if (bus.o_valid !== 1'b1) begin n_err++; $display("FAIL bp_o_valid: got %b want 1", bus.o_valid); end
    n_cmp++; if (bus.o_mx_count !== 6'd32) begin n_err++; $display("FAIL bp_held_count: got %0d want 32", bus.o_mx_count); end
    bus.i_ready = 1'b1;
    drain(10);
    n_cmp++;
    if (obs_q.size() != 2 || exp_q.size() != 2 || timeouts != t0) begin
      n_err++; $display("FAIL bp_nblocks: got %0d want 2", obs_q.size());
    end else begin
      n_cmp++; if (obs_cyc[1] !== obs_cyc[0] + 1) begin n_err++; $display("FAIL bp_no_bubble: got gap %0d want 1", obs_cyc[1] - obs_cyc[0]); end
      for (int i = 0; i < 2; i++) begin
        o = obs_q.pop_front();
        x = exp_q.pop_front();
        n_cmp++; if (o !== x) begin n_err++; $display("FAIL bp_block%0d: got %h want %h", i, o, x); end
      end
    end
    obs_cyc.delete();
  endtask

  task automatic test_back_to_back();
    blk_t o, x;
    int t0 = timeouts;
    int first, low0;
    bus.i_ready = 1'b1;
    send_beat(rand_beat(), 1'b0);
    first = fire_cyc;
    low0  = rdy_low;
    for (int b = 1; b < 4 * BEATS; b++) send_beat(rand_beat(), 1'b0);
    tick();
    n_cmp++; if (bus.o_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_back: got %b want 1", bus.o_ready); end
    n_cmp++; if (cyc - first != 36) begin n_err++; $display("FAIL b2b_cycles: got %0d want 36", cyc - first); end
    n_cmp++; if (rdy_low - low0 != 4) begin n_err++; $display("FAIL b2b_ready_low: got %0d want 4", rdy_low - low0); end
    drain(20);
    n_cmp++;
    if (obs_q.size() != 4 || exp_q.size() != 4 || timeouts != t0) begin
      n_err++; $display("FAIL b2b_nblocks: got %0d want 4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        o = obs_q.pop_front();
        x = exp_q.pop_front();
        n_cmp++; if (o !== x) begin n_err++; $display("FAIL b2b_block%0d: got %h want %h", i, o, x); end
      end
    end
    obs_cyc.delete();
  endtask

  task automatic test_reset_mid_fill();
    blk_t o, x;
    int t0 = timeouts;
    int seen = 0;
    bus.i_ready = 1'b1;
    for (int b = 0; b < 5; b++) send_beat(rand_beat(), 1'b0);
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.o_ready !== 1'b0) begin n_err++; $display("FAIL rst_forces_ready: got %b want 0", bus.o_ready); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.o_valid) seen++;
      tick();
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL rst_no_valid: got %0d valid cycles want 0", seen); end
    for (int b = 0; b < BEATS; b++) send_beat(rand_beat(), 1'b0);
    drain(20);
    n_cmp++;
    if (obs_q.size() != 1 || exp_q.size() != 1 || timeouts != t0) begin
      n_err++; $display("FAIL rst_nblocks: got %0d want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      x = exp_q.pop_front();
      n_cmp++; if (o.cnt !== 6'd32) begin n_err++; $display("FAIL rst_count: got %0d want 32", o.cnt); end
      n_cmp++; if (o !== x) begin n_err++; $display("FAIL rst_block: got %h want %h", o, x); end
    end
    obs_cyc.delete();
  endtask

  task automatic test_random();
    blk_t o, x;
    int t0 = timeouts;
    int sent = 0, bib = 0, n = 0, nobs;
    bus.i_valid = 1'b0;
    while (sent < 200 && n < 40000) begin
      if (!bus.i_valid && $urandom_range(0, 3) != 0) begin
        bus.i_valid = 1'b1;
        bus.i_data  = rand_beat();
        bus.i_last  = ($urandom_range(0, 5) == 0);
      end
      bus.i_ready = ($urandom_range(0, 9) < 7);
      tick();
      n++;
      if (last_in_fire) begin
        bib++;
        if (bus.i_last || bib == BEATS) begin
          sent++;
          bib = 0;
        end
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
      end
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    drain(50);
    nobs = obs_q.size();
    n_cmp++; if (nobs != 200 || timeouts != t0) begin n_err++; $display("FAIL rand_nblocks: got %0d want 200", nobs); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL rand_extra_block: got %h want none", o);
      end else begin
        x = exp_q.pop_front();
        if (o !== x) begin n_err++; $display("FAIL rand_block: got %h want %h", o, x); end
      end
    end
    n_cmp++; if (stab_viol != 0) begin n_err++; $display("FAIL stall_stability: got %0d changes want 0", stab_viol); end
    obs_cyc.delete();
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_short_block();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_fill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
